vga_sync_module: RTL
====================

VGA_SYNC_MODULE -- requirements
Module: vga_sync_module

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, HSYNC pulse width in clocks.
REQ-004 SHALL have parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, VSYNC pulse width in lines.
REQ-008 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL have port VGA_CLK, input, 1, pixel clock; one clock, all logic on its rising edge.
REQ-010 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-011 SHALL have port EN, input, 1, advance enable; low freezes counters and all outputs.
REQ-012 SHALL have port X, output, 10, current pixel column for vga_control_module.
REQ-013 SHALL have port Y, output, 10, current pixel row for vga_control_module.
REQ-014 SHALL have port valid, output, 1, high inside the visible area.
REQ-015 SHALL have port HSYNC, output, 1, horizontal sync, active-low.
REQ-016 SHALL have port VSYNC, output, 1, vertical sync, active-low.
REQ-017 SHALL have port FRAME_START, output, 1, one-clock pulse at pixel (0,0).

Function
REQ-018 SHALL keep h_cnt counting 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800 by default); it advances by one per clock while EN=1.
REQ-019 SHALL wrap h_cnt from H_TOTAL-1 to 0 and, on that same edge, advance v_cnt through 0..V_TOTAL-1 (525 by default).
REQ-020 SHALL wrap v_cnt from V_TOTAL-1 to 0 when h_cnt wraps on the last line; this is a simultaneous wrap of both counters.
REQ-021 SHALL register all outputs as decodes of the current counters, so outputs lag the counters by 1 clock.
REQ-022 SHALL drive valid=1 iff h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-023 SHALL drive X=h_cnt and Y=v_cnt when valid=1, and X=0 and Y=0 otherwise.
REQ-024 SHALL drive HSYNC=0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-025 SHALL drive VSYNC=0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default).
REQ-026 SHALL drive FRAME_START=1 for exactly one clock when h_cnt=0 and v_cnt=0; it is not repeated while EN=0 holds the count.
REQ-027 SHALL, while EN=0, hold the counters and all outputs at their last value; FRAME_START is forced to 0 after its first cycle.

Reset
REQ-028 SHALL, while RST=1, set h_cnt=0, v_cnt=0, X=0, Y=0, valid=0, HSYNC=1, VSYNC=1 and FRAME_START=0.
REQ-029 SHALL, in the first clock with RST=0 and EN=1, present outputs valid=1, X=0, Y=0 and FRAME_START=1.
REQ-030 SHALL, when RST is asserted mid-line or mid-frame, abort the frame; reset takes priority over EN.

Configuration
REQ-031 SHALL support macro VGA_SYNC_PIPE_ALIGN_EN.
REQ-032 SHALL, with VGA_SYNC_PIPE_ALIGN_EN defined, delay HSYNC, VSYNC and FRAME_START by one extra register stage, to align with the registered RGB of vga_control_module; X, Y and valid are not delayed.
REQ-033 SHALL give the extra stage reset values HSYNC=1, VSYNC=1, FRAME_START=0; the stage holds while EN=0.
REQ-034 SHALL, without VGA_SYNC_PIPE_ALIGN_EN, give all outputs the 1-clock latency of REQ-021.

Verification
REQ-035 SHALL pass: RST high 3 clocks then EN=1 -> FRAME_START=1, valid=1, X=0, Y=0 on the first clock after release.
REQ-036 SHALL pass: run one line -> valid high 640 clocks, low 160 clocks; HSYNC low exactly 96 clocks starting at h=656; X=639 on the last valid clock.
REQ-037 SHALL pass: run a full frame -> FRAME_START period of 420000 clocks; VSYNC low exactly 1600 clocks; Y=479 on the last valid line.
REQ-038 SHALL pass: EN=0 for 10 clocks at h=300,v=100 -> outputs frozen at X=300, Y=100; resume continues with X=301.
REQ-039 SHALL pass: RST pulse at h=700,v=200 -> reset values next clock, then restart at (0,0) with a FRAME_START pulse.
REQ-040 SHALL pass: with VGA_SYNC_PIPE_ALIGN_EN defined -> HSYNC falls 1 clock later than without the macro; X, Y and valid timing unchanged.

Source files
------------

// File: rtl/vga_sync_module.sv
// VGA timing generator: pixel/line counters with registered visible, X/Y, sync and frame-start decodes.
// Build macro VGA_SYNC_PIPE_ALIGN_EN adds one register stage on HSYNC, VSYNC and FRAME_START.
module vga_sync_module #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       VGA_CLK,
   input  logic       RST,
   input  logic       EN,
   output logic [9:0] X,
   output logic [9:0] Y,
   output logic       valid,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       FRAME_START
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          vis_d;
   logic          hs_d;
   logic          vs_d;
   logic          fs_d;
   logic          hs_q;
   logic          vs_q;
   logic          fs_q;

   // The line counter steps on the same edge the pixel counter wraps.
   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (EN) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      vis_d = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      hs_d  = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
      vs_d  = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
      fs_d  = (h_cnt == '0) && (v_cnt == '0);
   end

   // Frame start is cleared on hold so a frozen (0,0) never repeats the pulse.
   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         X     <= '0;
         Y     <= '0;
         valid <= 1'b0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else if (EN) begin
         X     <= vis_d ? 10'(h_cnt) : '0;
         Y     <= vis_d ? 10'(v_cnt) : '0;
         valid <= vis_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         fs_q  <= fs_d;
      end else begin
         fs_q  <= 1'b0;
      end
   end

`ifdef VGA_SYNC_PIPE_ALIGN_EN
   logic hs_p;
   logic vs_p;
   logic fs_p;

   // Extra stage lines syncs up with the registered RGB path downstream.
   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         hs_p <= 1'b1;
         vs_p <= 1'b1;
         fs_p <= 1'b0;
      end else if (EN) begin
         hs_p <= hs_q;
         vs_p <= vs_q;
         fs_p <= fs_q;
      end else begin
         fs_p <= 1'b0;
      end
   end

   assign HSYNC       = hs_p;
   assign VSYNC       = vs_p;
   assign FRAME_START = fs_p;
`else
   assign HSYNC       = hs_q;
   assign VSYNC       = vs_q;
   assign FRAME_START = fs_q;
`endif

endmodule
